sysid_check_master: RTL and testbench
=====================================

Name: sysid_check_master

Overview:
- Avalon-MM read-only master and the initiator counterpart of the system-ID slave (1-bit word address; word 0 = ID, word 1 = timestamp).
- After a trigger it reads both words, compares them against build-time expected values, and reports pass/fail on sticky status outputs.
- Sits beside the boot/debug logic so a hardware/software mismatch is flagged before the CPU is released.

Parameters:
- EXPECTED_ID, 0, expected value of word 0
- EXPECTED_TIMESTAMP, 1360941996, expected value of word 1
- TIMEOUT_CYCLES, 255, maximum cycles one read may be held off by waitrequest (1..65535)
- AUTO_START, 1, 1 = start one check automatically on the first cycle after reset release

Ports:
- clock  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that requests a check; ignored while busy
- address  out  1  Avalon word address to the sysid slave
- read  out  1  Avalon read strobe
- waitrequest  in  1  slave hold-off; tie 0 for the zero-wait sysid slave
- readdata  in  32  Avalon read data
- busy  out  1  check in progress
- done  out  1  sticky; a check has completed since the last start
- pass  out  1  sticky; both words matched (valid when done=1)
- id_ok  out  1  word 0 matched
- ts_ok  out  1  word 1 matched
- timeout  out  1  sticky; a read exceeded TIMEOUT_CYCLES
- captured_id  out  32  last value read from word 0
- captured_ts  out  32  last value read from word 1

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; address, read, busy, done, pass, id_ok, ts_ok, timeout = 0; captured_* = 0; wait counter = 0; auto-start flag = AUTO_START.
- FSM states: IDLE, RD_ID, RD_TS, EVAL, FINISH.
- IDLE:
  - Go to RD_ID when (start=1) or (auto-start flag=1); clear the auto-start flag.
  - On entry to RD_ID: clear done, pass, id_ok, ts_ok and timeout; set busy=1.
- RD_ID:
  - Drive read=1, address=0.
  - Transfer completes on the first cycle with read=1 && waitrequest=0. Register readdata into captured_id on that edge (zero read latency; readdatavalid is not used).
  - Then go to RD_TS.
- RD_TS: same handshake with address=1; capture into captured_ts; then go to EVAL.
- Wait counter:
  - Increments on each cycle with read=1 && waitrequest=1.
  - Cleared on every completed transfer and on state change.
  - When the count reaches TIMEOUT_CYCLES while still held off: drop read the next cycle, set timeout=1, go to FINISH with pass=0, id_ok=0, ts_ok=0.
- EVAL (one cycle):
  - id_ok = (captured_id == EXPECTED_ID)
  - ts_ok = (captured_ts == EXPECTED_TIMESTAMP)
  - pass = id_ok && ts_ok
  - All compares are full 32-bit unsigned equality.
- FINISH (one cycle): done=1, busy=0, then go to IDLE.
- Timing, zero-wait slave: read is high for 2 cycles; done rises 4 cycles after the start sample (RD_ID, RD_TS, EVAL, FINISH).
- address and read change only on state transitions. read is never high in IDLE, EVAL or FINISH.
- start pulses arriving while busy=1 are ignored, not queued.
- start in the same cycle that FINISH returns to IDLE is ignored. start is sampled only in IDLE.
- Status outputs hold until the next accepted start.
- Reset asserted mid-transaction: read drops immediately (asynchronous), all outputs return to reset values, and the auto-start flag re-arms.
- Wait counter is 16 bits and saturates; it never wraps.

Decomposition:
- Shared package sysid_pkg:
  - state enum (IDLE, RD_ID, RD_TS, EVAL, FINISH)
  - SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1
  - DATA_W=32
- One natural sub-module: avalon_read_timer, the saturating hold-off counter with clear and expire flag. The FSM stays in the top level.

Test Plan:
- Zero-wait slave returning 0 / 1360941996 with AUTO_START=1 -> after reset release, read high 2 cycles at addresses 0 then 1; done=1, pass=1, id_ok=1, ts_ok=1 four cycles later.
- Slave returns timestamp 1360941995 after a start pulse -> done=1, id_ok=1, ts_ok=0, pass=0, captured_ts=1360941995.
- waitrequest held 3 cycles on word 0, TIMEOUT_CYCLES=255 -> read held with address=0 for 4 cycles; value captured on the 4th cycle; check passes; timeout=0.
- waitrequest stuck at 1, TIMEOUT_CYCLES=8 -> read drops after 8 held cycles; timeout=1, done=1, pass=0; no read at address 1.
- start pulses on every cycle during a check -> exactly one read pair per check; second check begins only after done with busy=0.
- reset_n pulsed low while in RD_TS -> read=0 and busy=0 within the reset cycle; with AUTO_START=1 a fresh check starts after release and completes with pass=1.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID check master and its hold-off timer.
package sysid_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAIT_W = 16;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        RD_TS  = 3'd2,
        EVAL   = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Sticky result flags reported to the boot/debug logic.
    typedef struct packed {
        logic done;
        logic pass;
        logic id_ok;
        logic ts_ok;
        logic timeout;
    } status_t;

endpackage

// File: rtl/avalon_read_timer.sv
// Saturating waitrequest hold-off counter; flags expiry on the cycle the limit is reached.
module avalon_read_timer
    import sysid_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_expire_c
);

    localparam logic [WAIT_W-1:0] CNT_MAX  = '1;
    localparam logic [WAIT_W-1:0] LIMIT_M1 = WAIT_W'(LIMIT - 1);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_hold && (r_count != CNT_MAX)) begin
            r_count <= r_count + WAIT_W'(1);
        end
    end

    // Current held cycle is the LIMIT-th one in a row.
    assign o_expire_c = i_hold && (r_count >= LIMIT_M1);

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read-only master: reads sysid ID and timestamp, compares them with
// build-time values and reports sticky pass/fail/timeout status.
module sysid_check_master
    import sysid_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID        = 32'd0,
    parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1360941996,
    parameter int unsigned       TIMEOUT_CYCLES     = 255,
    parameter bit                AUTO_START         = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              address,
    output logic              read,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              timeout,
    output logic [DATA_W-1:0] captured_id,
    output logic [DATA_W-1:0] captured_ts
);

    state_t            r_state, w_next;
    status_t           r_stat, w_stat;
    logic              r_auto, w_auto;
    logic              r_busy, w_busy;
    logic              r_read, w_read;
    logic              r_addr, w_addr;
    logic [DATA_W-1:0] r_cap_id, w_cap_id;
    logic [DATA_W-1:0] r_cap_ts, w_cap_ts;

    logic w_xfer;
    logic w_hold;
    logic w_clear;
    logic w_expire;

    assign w_xfer  = r_read && !waitrequest;
    assign w_hold  = r_read && waitrequest;
    assign w_clear = w_xfer || (w_next != r_state);

    avalon_read_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clock),
        .rst_n      (reset_n),
        .i_clear    (w_clear),
        .i_hold     (w_hold),
        .o_expire_c (w_expire)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        w_next   = r_state;
        w_stat   = r_stat;
        w_auto   = r_auto;
        w_busy   = r_busy;
        w_cap_id = r_cap_id;
        w_cap_ts = r_cap_ts;

        case (r_state)
            IDLE: begin
                if (start || r_auto) begin
                    w_next = RD_ID;
                    w_auto = 1'b0;
                    w_stat = '0;
                    w_busy = 1'b1;
                end
            end
            RD_ID: begin
                if (w_xfer) begin
                    w_cap_id = readdata;
                    w_next   = RD_TS;
                end else if (w_expire) begin
                    w_next         = FINISH;
                    w_stat.timeout = 1'b1;
                    w_stat.pass    = 1'b0;
                    w_stat.id_ok   = 1'b0;
                    w_stat.ts_ok   = 1'b0;
                end
            end
            RD_TS: begin
                if (w_xfer) begin
                    w_cap_ts = readdata;
                    w_next   = EVAL;
                end else if (w_expire) begin
                    w_next         = FINISH;
                    w_stat.timeout = 1'b1;
                    w_stat.pass    = 1'b0;
                    w_stat.id_ok   = 1'b0;
                    w_stat.ts_ok   = 1'b0;
                end
            end
            EVAL: begin
                w_stat.id_ok = (r_cap_id == EXPECTED_ID);
                w_stat.ts_ok = (r_cap_ts == EXPECTED_TIMESTAMP);
                w_stat.pass  = (r_cap_id == EXPECTED_ID) && (r_cap_ts == EXPECTED_TIMESTAMP);
                w_next       = FINISH;
            end
            FINISH: begin
                w_stat.done = 1'b1;
                w_busy      = 1'b0;
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        // Bus strobes follow the state being entered, so they only move on transitions.
        w_read = (w_next == RD_ID) || (w_next == RD_TS);
        w_addr = (w_next == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_stat   <= '0;
            r_auto   <= AUTO_START;
            r_busy   <= 1'b0;
            r_read   <= 1'b0;
            r_addr   <= SYSID_ADDR_ID;
            r_cap_id <= '0;
            r_cap_ts <= '0;
        end else begin
            r_state  <= w_next;
            r_stat   <= w_stat;
            r_auto   <= w_auto;
            r_busy   <= w_busy;
            r_read   <= w_read;
            r_addr   <= w_addr;
            r_cap_id <= w_cap_id;
            r_cap_ts <= w_cap_ts;
        end
    end

    assign address     = r_addr;
    assign read        = r_read;
    assign busy        = r_busy;
    assign done        = r_stat.done;
    assign pass        = r_stat.pass;
    assign id_ok       = r_stat.id_ok;
    assign ts_ok       = r_stat.ts_ok;
    assign timeout     = r_stat.timeout;
    assign captured_id = r_cap_id;
    assign captured_ts = r_cap_ts;

endmodule

// File: tb/tb_sysid_check_master.sv
// Self-checking bench for sysid_check_master with a small programmable sysid slave.
module tb_sysid_check_master;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1360941996;

    logic        clock, reset_n, start;
    logic        address, read, waitrequest;
    logic [31:0] readdata;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] captured_id, captured_ts;

    typedef struct packed {
        logic        addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t obs_q[$];

    logic [31:0] slv_id, slv_ts;
    int          hold_id, hold_ts, held_cnt;
    bit          stuck;
    int          n_vec, n_err, rd_hi0, rd_hi1;

    sysid_check_master #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (8),
        .AUTO_START         (1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .address     (address),
        .read        (read),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .timeout     (timeout),
        .captured_id (captured_id),
        .captured_ts (captured_ts)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Slave: zero read latency, programmable hold-off per word or stuck hold-off.
    always_comb begin
        readdata    = address ? slv_ts : slv_id;
        waitrequest = read && (stuck || (held_cnt < (address ? hold_ts : hold_id)));
    end

    always @(posedge clock) held_cnt <= (read && waitrequest) ? held_cnt + 1 : 0;

    task automatic tick();
        @(negedge clock);
        if (read) begin
            if (address) rd_hi1++;
            else         rd_hi0++;
            if (!waitrequest) obs_q.push_back({address, readdata});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(done && !busy) && cyc < budget);
    endtask

    task automatic test_reset();
        int   cyc;
        txn_t e, o;
        reset_n = 1'b0;
        tick();
        tick();
        n_vec++; if (read !== 1'b0 || busy !== 1'b0 || address !== 1'b0) begin n_err++; $display("FAIL reset_bus: read=%b busy=%b addr=%b, required 0/0/0", read, busy, address); end
        n_vec++; if ({done, pass, id_ok, ts_ok, timeout} !== 5'b0) begin n_err++; $display("FAIL reset_status: %b, required 00000", {done, pass, id_ok, ts_ok, timeout}); end
        n_vec++; if (captured_id !== 32'd0 || captured_ts !== 32'd0) begin n_err++; $display("FAIL reset_capture: %h/%h, required 0/0", captured_id, captured_ts); end
        rd_hi0 = 0; rd_hi1 = 0;
        exp_q.push_back({1'b0, EXP_ID});
        exp_q.push_back({1'b1, EXP_TS});
        reset_n = 1'b1;
        wait_done(50, cyc);
        n_vec++; if (cyc !== 5 || done !== 1'b1) begin n_err++; $display("FAIL auto_latency: done=%b after %0d cycles, required 1 after 5", done, cyc); end
        n_vec++; if (rd_hi0 !== 1 || rd_hi1 !== 1) begin n_err++; $display("FAIL auto_read_len: %0d/%0d cycles, required 1/1", rd_hi0, rd_hi1); end
        n_vec++; if ({pass, id_ok, ts_ok, timeout} !== 4'b1110) begin n_err++; $display("FAIL auto_result: %b, required 1110", {pass, id_ok, ts_ok, timeout}); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL auto_txn: none, required %0d:%h", e.addr, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL auto_txn: %0d:%h, required %0d:%h", o.addr, o.data, e.addr, e.data); end end
        end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL auto_extra: %0d extra transfers, required 0", obs_q.size()); end
    endtask

    task automatic test_ts_mismatch();
        int   cyc;
        txn_t e, o;
        slv_ts = 32'd1360941995;
        exp_q.push_back({1'b0, EXP_ID});
        exp_q.push_back({1'b1, 32'd1360941995});
        pulse_start();
        wait_done(50, cyc);
        n_vec++; if ({done, pass, id_ok, ts_ok, timeout} !== 5'b10100) begin n_err++; $display("FAIL ts_bad_result: %b, required 10100", {done, pass, id_ok, ts_ok, timeout}); end
        n_vec++; if (captured_ts !== 32'd1360941995) begin n_err++; $display("FAIL ts_bad_capture: %0d, required 1360941995", captured_ts); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL ts_bad_txn: none, required %0d:%h", e.addr, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL ts_bad_txn: %0d:%h, required %0d:%h", o.addr, o.data, e.addr, e.data); end end
        end
        repeat (3) tick();
        n_vec++; if (done !== 1'b1 || pass !== 1'b0 || read !== 1'b0) begin n_err++; $display("FAIL ts_bad_hold: done=%b pass=%b read=%b, required 1/0/0", done, pass, read); end
        slv_ts = EXP_TS;
    endtask

    task automatic test_wait_id();
        int   cyc;
        txn_t e, o;
        hold_id = 3;
        rd_hi0 = 0; rd_hi1 = 0;
        exp_q.push_back({1'b0, EXP_ID});
        exp_q.push_back({1'b1, EXP_TS});
        pulse_start();
        wait_done(50, cyc);
        n_vec++; if (rd_hi0 !== 4 || rd_hi1 !== 1) begin n_err++; $display("FAIL wait_read_len: %0d/%0d cycles, required 4/1", rd_hi0, rd_hi1); end
        n_vec++; if ({done, pass, id_ok, ts_ok, timeout} !== 5'b11110) begin n_err++; $display("FAIL wait_result: %b, required 11110", {done, pass, id_ok, ts_ok, timeout}); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL wait_txn: none, required %0d:%h", e.addr, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL wait_txn: %0d:%h, required %0d:%h", o.addr, o.data, e.addr, e.data); end end
        end
        hold_id = 0;
    endtask

    task automatic test_timeout();
        int cyc;
        stuck = 1'b1;
        rd_hi0 = 0; rd_hi1 = 0;
        obs_q.delete();
        pulse_start();
        wait_done(60, cyc);
        n_vec++; if (rd_hi0 !== 8 || rd_hi1 !== 0) begin n_err++; $display("FAIL tmo_read_len: %0d/%0d cycles, required 8/0", rd_hi0, rd_hi1); end
        n_vec++; if ({done, pass, id_ok, ts_ok, timeout} !== 5'b10001) begin n_err++; $display("FAIL tmo_result: %b, required 10001", {done, pass, id_ok, ts_ok, timeout}); end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL tmo_txn: %0d transfers, required 0", obs_q.size()); end
        stuck = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   cyc;
        txn_t e, o;
        obs_q.delete();
        rd_hi0 = 0; rd_hi1 = 0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, EXP_ID});
            exp_q.push_back({1'b1, EXP_TS});
        end
        start = 1'b1;
        tick();
        wait_done(50, cyc);
        n_vec++; if (obs_q.size() != 2 || busy !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL b2b_first: %0d transfers busy=%b done=%b, required 2/0/1", obs_q.size(), busy, done); end
        tick();
        n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_restart: busy=%b done=%b, required 1/0", busy, done); end
        wait_done(50, cyc);
        start = 1'b0;
        n_vec++; if (rd_hi0 !== 2 || rd_hi1 !== 2 || pass !== 1'b1) begin n_err++; $display("FAIL b2b_reads: %0d/%0d pass=%b, required 2/2/1", rd_hi0, rd_hi1, pass); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL b2b_txn: none, required %0d:%h", e.addr, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL b2b_txn: %0d:%h, required %0d:%h", o.addr, o.data, e.addr, e.data); end end
        end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL b2b_extra: %0d extra transfers, required 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        txn_t e, o;
        hold_ts = 5;
        pulse_start();
        for (int i = 0; i < 20 && !(read && address); i++) tick();
        n_vec++; if (!(read === 1'b1 && address === 1'b1)) begin n_err++; $display("FAIL mid_reach_ts: read=%b addr=%b, required 1/1", read, address); end
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (read !== 1'b0 || busy !== 1'b0 || address !== 1'b0) begin n_err++; $display("FAIL mid_reset_drop: read=%b busy=%b addr=%b, required 0/0/0", read, busy, address); end
        n_vec++; if (captured_id !== 32'd0 || done !== 1'b0) begin n_err++; $display("FAIL mid_reset_clear: id=%h done=%b, required 0/0", captured_id, done); end
        tick();
        hold_ts = 0;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({1'b0, EXP_ID});
        exp_q.push_back({1'b1, EXP_TS});
        reset_n = 1'b1;
        wait_done(50, cyc);
        n_vec++; if (cyc !== 5 || {done, pass, timeout} !== 3'b110) begin n_err++; $display("FAIL mid_rearm: %0d cycles status %b, required 5 / 110", cyc, {done, pass, timeout}); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL mid_txn: none, required %0d:%h", e.addr, e.data); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL mid_txn: %0d:%h, required %0d:%h", o.addr, o.data, e.addr, e.data); end end
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        start   = 1'b0;
        reset_n = 1'b0;
        slv_id  = EXP_ID;
        slv_ts  = EXP_TS;
        hold_id = 0;
        hold_ts = 0;
        stuck   = 1'b0;
        test_reset();
        test_ts_mismatch();
        test_wait_id();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
